// File: rtl/tlb_miss_sequencer_if.sv
// Bundle between the ITLB/DTLB miss requesters, the shared page-table walker and the miss sequencer.
// The master modport is the sequencer's view; the slave modport is the TLB/PTW side.
interface tlb_miss_sequencer_if #(
   parameter int XLEN        = 64,
   parameter int SVMODE_BITS = 4
);
   logic [SVMODE_BITS-1:0] SATP_MODE;
   logic                   ITLBMiss;
   logic [XLEN-1:0]        IVAdr;
   logic                   DTLBMiss;
   logic [XLEN-1:0]        DVAdr;
   logic                   DIsStore;
   logic                   Flush;
   logic                   WalkReq;
   logic [XLEN-1:0]        WalkVAdr;
   logic                   WalkSel;
   logic                   WalkDone;
   logic                   WalkFault;
   logic                   ITLBDone;
   logic                   DTLBDone;
   logic                   InstrPageFault;
   logic                   LoadPageFault;
   logic                   StorePageFault;
   logic                   WalkTimeout;
   logic                   Busy;

   modport master (
      input  SATP_MODE, ITLBMiss, IVAdr, DTLBMiss, DVAdr, DIsStore, Flush,
      input  WalkDone, WalkFault,
      output WalkReq, WalkVAdr, WalkSel,
      output ITLBDone, DTLBDone, InstrPageFault, LoadPageFault, StorePageFault,
      output WalkTimeout, Busy
   );

   modport slave (
      output SATP_MODE, ITLBMiss, IVAdr, DTLBMiss, DVAdr, DIsStore, Flush,
      output WalkDone, WalkFault,
      input  WalkReq, WalkVAdr, WalkSel,
      input  ITLBDone, DTLBDone, InstrPageFault, LoadPageFault, StorePageFault,
      input  WalkTimeout, Busy
   );
endinterface

// File: rtl/tlb_miss_sequencer.sv
// Round-robin arbiter of ITLB/DTLB misses onto the shared page-table walker, with canonical-address
// screening under Sv39/Sv48, a walk watchdog, and one-cycle done/fault pulses back to the requester.
module tlb_miss_sequencer #(
   parameter int                     XLEN        = 64,
   parameter int                     SVMODE_BITS = 4,
   parameter logic [SVMODE_BITS-1:0] SV39        = SVMODE_BITS'(8),
   parameter logic [SVMODE_BITS-1:0] SV48        = SVMODE_BITS'(9),
   parameter int                     TIMEOUT_CYC = 1024
) (
   input logic                   clk,
   input logic                   reset,
   tlb_miss_sequencer_if.master  bus
);

   localparam int                CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      WALK  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              sel_q, sel_d;
   logic              store_q, store_d;
   logic [XLEN-1:0]   vadr_q, vadr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              walk_req_q, walk_req_d;
   logic              itlb_done_q, itlb_done_d;
   logic              dtlb_done_q, dtlb_done_d;
   logic              ipf_q, ipf_d;
   logic              lpf_q, lpf_d;
   logic              spf_q, spf_d;
   logic              timeout_q, timeout_d;

   logic              grant;
   logic              resp_fire;
   logic              resp_fault;
   logic              resp_timeout;
   logic              screen_walk;
   logic              screen_fault;

   // Only a 64-bit datapath is screened; narrower builds walk every miss unconditionally.
   if (XLEN == 64) begin : g_screen
      logic canon39, canon48;
      assign canon39      = (&vadr_q[63:38]) | ~(|vadr_q[63:38]);
      assign canon48      = (&vadr_q[63:47]) | ~(|vadr_q[63:47]);
      assign screen_walk  = ((bus.SATP_MODE == SV39) & canon39) | ((bus.SATP_MODE == SV48) & canon48);
      assign screen_fault = ((bus.SATP_MODE == SV39) & ~canon39) | ((bus.SATP_MODE == SV48) & ~canon48);
   end else begin : g_noscreen
      assign screen_walk  = 1'b1;
      assign screen_fault = 1'b0;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      sel_d        = sel_q;
      store_d      = store_q;
      vadr_d       = vadr_q;
      cnt_d        = cnt_q;
      walk_req_d   = 1'b0;
      grant        = 1'b0;
      resp_fire    = 1'b0;
      resp_fault   = 1'b0;
      resp_timeout = 1'b0;

      if (bus.Flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.ITLBMiss || bus.DTLBMiss) begin
                  grant        = (bus.ITLBMiss && bus.DTLBMiss) ? ~last_grant_q : bus.DTLBMiss;
                  last_grant_d = grant;
                  sel_d        = grant;
                  store_d      = grant & bus.DIsStore;
                  vadr_d       = grant ? bus.DVAdr : bus.IVAdr;
                  state_d      = CHECK;
               end
            end
            CHECK: begin
               if (screen_walk) begin
                  state_d    = WALK;
                  cnt_d      = '0;
                  walk_req_d = 1'b1;
               end else begin
                  state_d    = RESP;
                  resp_fire  = 1'b1;
                  resp_fault = screen_fault;
               end
            end
            WALK: begin
               // A completion arriving on the final watchdog cycle takes priority over the timeout.
               if (bus.WalkDone && walk_req_q) begin
                  state_d    = RESP;
                  resp_fire  = 1'b1;
                  resp_fault = bus.WalkFault;
               end else if (cnt_q == CNT_LAST) begin
                  state_d      = RESP;
                  resp_fire    = 1'b1;
                  resp_fault   = 1'b1;
                  resp_timeout = 1'b1;
               end else begin
                  cnt_d      = cnt_q + CNT_W'(1);
                  walk_req_d = 1'b1;
               end
            end
            RESP: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      itlb_done_d = resp_fire & ~sel_q & ~resp_fault;
      ipf_d       = resp_fire & ~sel_q &  resp_fault;
      dtlb_done_d = resp_fire &  sel_q & ~resp_fault;
      spf_d       = resp_fire &  sel_q &  resp_fault &  store_q;
      lpf_d       = resp_fire &  sel_q &  resp_fault & ~store_q;
      timeout_d   = resp_fire & resp_timeout;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b0;
         sel_q        <= 1'b0;
         store_q      <= 1'b0;
         vadr_q       <= '0;
         cnt_q        <= '0;
         walk_req_q   <= 1'b0;
         itlb_done_q  <= 1'b0;
         dtlb_done_q  <= 1'b0;
         ipf_q        <= 1'b0;
         lpf_q        <= 1'b0;
         spf_q        <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         store_q      <= store_d;
         vadr_q       <= vadr_d;
         cnt_q        <= cnt_d;
         walk_req_q   <= walk_req_d;
         itlb_done_q  <= itlb_done_d;
         dtlb_done_q  <= dtlb_done_d;
         ipf_q        <= ipf_d;
         lpf_q        <= lpf_d;
         spf_q        <= spf_d;
         timeout_q    <= timeout_d;
      end
   end

   // Pulses are registered but squashed by a flush arriving in the response cycle itself.
   assign bus.ITLBDone       = itlb_done_q & ~bus.Flush;
   assign bus.DTLBDone       = dtlb_done_q & ~bus.Flush;
   assign bus.InstrPageFault = ipf_q       & ~bus.Flush;
   assign bus.LoadPageFault  = lpf_q       & ~bus.Flush;
   assign bus.StorePageFault = spf_q       & ~bus.Flush;
   assign bus.WalkTimeout    = timeout_q   & ~bus.Flush;
   assign bus.WalkReq        = walk_req_q;
   assign bus.WalkVAdr       = vadr_q;
   assign bus.WalkSel        = sel_q;
   assign bus.Busy           = (state_q != IDLE);

endmodule
